test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
- Runs NUM_TESTS sub-blocks strictly one after another, reusing one harness for any test count.
- For each sub-block: launches it, waits for its completion, and records pass/fail/timeout.
- After the last test, reports an aggregate verdict.
- Used in simulation top-levels to order sub-benches, and in hardware as a power-on self-test sequencer for EconoPET blocks.
- Adds over a fixed call list: parametrised test count, per-test watchdog timeout, stop-on-fail mode, and a per-test result mask.

Parameters:
- NUM_TESTS, 4, number of sequenced tests (1..32).
- TIMEOUT_CYCLES, 65536, clock cycles a test may run before it is declared timed out (>=2).
- CLK_MHZ, 64, informational only; no logic depends on it.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- stop_on_fail_i  in  1  when 1, abort the sequence after the first failing test; sampled at start.
- test_start_o  out  NUM_TESTS  one-hot, single-cycle launch pulse to test n.
- test_done_i  in  NUM_TESTS  completion pulse or level from test n.
- test_pass_i  in  NUM_TESTS  verdict of test n; valid in the same cycle as test_done_i[n].
- busy_o  out  1  high from start acceptance through FINISH.
- done_o  out  1  single-cycle pulse when the sequence ends.
- pass_o  out  1  aggregate verdict; valid from done_o until the next start.
- fail_mask_o  out  NUM_TESTS  bit n=1 if test n failed or timed out.
- timeout_mask_o  out  NUM_TESTS  bit n=1 if test n timed out.
- run_mask_o  out  NUM_TESTS  bit n=1 if test n was launched.
- current_o  out  IW  index of the active test; IW = max(1, $clog2(NUM_TESTS)).

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; index 0; watchdog 0.
  - Reset mid-sequence aborts immediately: no done_o, masks cleared, no further test_start_o.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - start_i=1 at edge k: clear all masks, clear pass_o, latch stop_on_fail_i, index=0, move to LAUNCH.
  - busy_o=1 from cycle k+1.
- LAUNCH (exactly 1 cycle):
  - test_start_o[index]=1; set run_mask_o[index].
  - Clear the watchdog; move to WAIT at the next edge.
  - start_i fires test 0 at cycle k+1.
- WAIT: evaluate at each edge in this priority order.
  - a) test_done_i[index]=1: if test_pass_i[index]=0, set fail_mask_o[index]. Then advance.
  - b) Else, watchdog == TIMEOUT_CYCLES-1: set fail_mask_o[index] and timeout_mask_o[index]. Then advance.
  - c) Else: watchdog += 1.
  - Done and timeout in the same cycle: done wins; no timeout is recorded.
  - test_done_i bits for any index other than the active one are ignored.
  - Timing: a test whose done first appears N cycles after its launch pulse (N >= 1) is accepted if N <= TIMEOUT_CYCLES. With no done, the timeout edge falls TIMEOUT_CYCLES cycles after the launch pulse.
- Advance rule:
  - If index == NUM_TESTS-1, or (a failure was just recorded and the latched stop_on_fail is 1): go to FINISH.
  - Otherwise: index += 1, go to LAUNCH. The next test's launch pulse falls in the cycle right after the accepting edge.
- FINISH (1 cycle):
  - done_o=1.
  - pass_o = (fail_mask == 0), registered and held until the next start.
  - Next edge: IDLE, busy_o=0. Masks are held until the next start.
- Busy and reporting rules:
  - start_i while busy_o=1 is ignored; no restart, no queuing.
  - current_o follows the index and holds its last value in IDLE.
- Width rules:
  - Watchdog width is $clog2(TIMEOUT_CYCLES); no wrap is possible.
  - Index compare uses NUM_TESTS-1 at width IW.
  - NUM_TESTS=1: IW=1; index is always 0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- All 4 tests pass:
  - Stimulus: each asserts done+pass 5 cycles after its launch.
  - Required: launches at cycles 1, 7, 13, 19; done_o in one cycle; pass_o=1; fail_mask_o=0000; run_mask_o=1111.
- Test 1 fails, stop_on_fail_i=0:
  - Required: all 4 launched; fail_mask_o=0010; pass_o=0; timeout_mask_o=0000.
- Test 2 fails, stop_on_fail_i=1:
  - Required: test 3 never launched; run_mask_o=0111; fail_mask_o=0100; done_o pulses.
- TIMEOUT_CYCLES=16, test 0 never completes:
  - Required: timeout edge 16 cycles after its launch; timeout_mask_o=0001; fail_mask_o=0001.
  - The sequence continues to test 1.
- TIMEOUT_CYCLES=16, done+pass arriving exactly 16 cycles after launch:
  - Required: recorded as pass, no timeout.
- Reset and busy handling:
  - Assert reset_i while test 2 is in WAIT: all outputs return to 0 asynchronously; no done_o afterwards.
  - Subsequent start_i runs cleanly from test 0.
  - A second start_i while busy has no effect.

Source files
------------

// File: rtl/test_sequencer_if.sv
// Purpose: bundles the sequencer's control, verdict and per-test handshake signals.
// Latency: none, this is wiring only.
// Backpressure: none; tests report completion with test_done_i whenever they finish.
// Ports: master = the sequencer (drives launches and verdicts), slave = the harness and tests.
interface test_sequencer_if #(
  parameter int NUM_TESTS = 4
);
  localparam int IW = (NUM_TESTS > 2) ? $clog2(NUM_TESTS) : 1;

  logic                 start_i;
  logic                 stop_on_fail_i;
  logic [NUM_TESTS-1:0] test_start_o;
  logic [NUM_TESTS-1:0] test_done_i;
  logic [NUM_TESTS-1:0] test_pass_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 pass_o;
  logic [NUM_TESTS-1:0] fail_mask_o;
  logic [NUM_TESTS-1:0] timeout_mask_o;
  logic [NUM_TESTS-1:0] run_mask_o;
  logic [IW-1:0]        current_o;

  modport master (
    input  start_i, stop_on_fail_i, test_done_i, test_pass_i,
    output test_start_o, busy_o, done_o, pass_o,
           fail_mask_o, timeout_mask_o, run_mask_o, current_o
  );

  modport slave (
    output start_i, stop_on_fail_i, test_done_i, test_pass_i,
    input  test_start_o, busy_o, done_o, pass_o,
           fail_mask_o, timeout_mask_o, run_mask_o, current_o
  );
endinterface

// File: rtl/test_sequencer.sv
// Purpose: launches NUM_TESTS tests one at a time, collects pass/fail/timeout, reports a verdict.
// Latency: first launch 1 cycle after start; next launch 1 cycle after a completion; done_o 1 cycle after the last.
// Backpressure: start_i is ignored while busy; each test is bounded by a TIMEOUT_CYCLES watchdog.
// Ports: clock_i/reset_i (async, active-high); bus.master carries start/stop_on_fail in,
//        per-test start/done/pass, and busy/done/pass/fail/timeout/run masks plus current index out.
module test_sequencer #(
  parameter int NUM_TESTS      = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CLK_MHZ        = 64
) (
  input  logic clock_i,
  input  logic reset_i,
  test_sequencer_if.master bus
);
  localparam int IW = (NUM_TESTS > 2) ? $clog2(NUM_TESTS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_TESTS - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  // CLK_MHZ is documentation only; it appears here solely in the parameter sanity check.
  if (NUM_TESTS < 1 || NUM_TESTS > 32 || TIMEOUT_CYCLES < 2 || CLK_MHZ < 1) begin : g_bad_param
    $error("test_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic                 sof_q, sof_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [NUM_TESTS-1:0] test_start_q, test_start_d;
  logic [NUM_TESTS-1:0] fail_q, fail_d;
  logic [NUM_TESTS-1:0] tmo_q, tmo_d;
  logic [NUM_TESTS-1:0] run_q, run_d;
  logic                 advance;
  logic                 failed;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    sof_d        = sof_q;
    busy_d       = busy_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    tmo_d        = tmo_q;
    run_d        = run_q;
    test_start_d = '0;
    done_d       = 1'b0;
    advance      = 1'b0;
    failed       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          fail_d          = '0;
          tmo_d           = '0;
          run_d           = '0;
          pass_d          = 1'b0;
          sof_d           = bus.stop_on_fail_i;
          idx_d           = '0;
          busy_d          = 1'b1;
          state_d         = S_LAUNCH;
          // Launch pulse and run bit are registered, so they are set on
          // the edge that enters LAUNCH and are visible during LAUNCH.
          test_start_d[0] = 1'b1;
          run_d[0]        = 1'b1;
        end
      end

      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Completion outranks the watchdog when both land on the same edge.
        if (bus.test_done_i[idx_q]) begin
          advance = 1'b1;
          if (!bus.test_pass_i[idx_q]) begin
            fail_d[idx_q] = 1'b1;
            failed        = 1'b1;
          end
        end else if (wd_q == WD_LAST) begin
          advance       = 1'b1;
          fail_d[idx_q] = 1'b1;
          tmo_d[idx_q]  = 1'b1;
          failed        = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end

        if (advance) begin
          if (idx_q == IDX_LAST || (failed && sof_q)) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            pass_d  = (fail_d == '0);
          end else begin
            idx_d               = idx_q + IW'(1);
            state_d             = S_LAUNCH;
            test_start_d[idx_d] = 1'b1;
            run_d[idx_d]        = 1'b1;
          end
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wd_q         <= '0;
      sof_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      test_start_q <= '0;
      fail_q       <= '0;
      tmo_q        <= '0;
      run_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      sof_q        <= sof_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      test_start_q <= test_start_d;
      fail_q       <= fail_d;
      tmo_q        <= tmo_d;
      run_q        <= run_d;
    end
  end

  assign bus.test_start_o   = test_start_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.pass_o         = pass_q;
  assign bus.fail_mask_o    = fail_q;
  assign bus.timeout_mask_o = tmo_q;
  assign bus.run_mask_o     = run_q;
  assign bus.current_o      = idx_q;
endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;
  localparam int NT = 4;
  localparam int T  = 16;

  logic clock_i = 1'b0;
  logic reset_i;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  test_sequencer_if #(.NUM_TESTS(NT)) bus ();

  test_sequencer #(.NUM_TESTS(NT), .TIMEOUT_CYCLES(T)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  // Test plan: per-test response delay after launch (0 = never answers) and verdict.
  int p_d [NT];
  bit p_pass [NT];
  bit p_sof;

  // Expected timeline derived from the plan.
  int m_L [NT];
  int m_a [NT];
  bit m_launched [NT];
  bit m_failed [NT];
  bit m_tmo [NT];
  int m_s;
  int m_done;
  bit m_verdict;

  bit chk_en  = 1'b0;
  bit resp_en = 1'b0;
  int n_done  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // s = cycle in which test 0's launch pulse is visible. A test launched in cycle L
  // whose done shows in cycle L+d is accepted at the end of that cycle; without an
  // answer, the verdict is taken at the end of cycle L+T. Effects show one cycle later.
  function automatic void build_model(input int s);
    int t;
    bit stop;
    t    = s;
    stop = 1'b0;
    m_s  = s;
    for (int n = 0; n < NT; n++) begin
      m_launched[n] = 1'b0;
      m_failed[n]   = 1'b0;
      m_tmo[n]      = 1'b0;
      m_L[n]        = 0;
      m_a[n]        = 0;
    end
    for (int n = 0; n < NT; n++) begin
      if (!stop) begin
        m_launched[n] = 1'b1;
        m_L[n]        = t;
        if (p_d[n] >= 1 && p_d[n] <= T) begin
          m_a[n]      = t + p_d[n];
          m_failed[n] = !p_pass[n];
        end else begin
          m_a[n]      = t + T;
          m_failed[n] = 1'b1;
          m_tmo[n]    = 1'b1;
        end
        if (n == NT - 1 || (m_failed[n] && p_sof)) begin
          stop   = 1'b1;
          m_done = m_a[n] + 1;
        end
        t = m_a[n] + 1;
      end
    end
    m_verdict = 1'b1;
    for (int n = 0; n < NT; n++)
      if (m_failed[n]) m_verdict = 1'b0;
  endfunction

  // Test responder: answers for the active test exactly when planned, random noise on
  // every bit whose test is not currently active.
  always @(posedge clock_i) begin : responder
    logic [NT-1:0] dn;
    logic [NT-1:0] ps;
    #1;
    dn = '0;
    ps = '0;
    if (resp_en) begin
      for (int n = 0; n < NT; n++) begin
        if (m_launched[n] && cyc >= m_L[n] && cyc <= m_a[n]) begin
          dn[n] = (p_d[n] >= 1 && p_d[n] <= T && cyc == m_L[n] + p_d[n]);
          ps[n] = dn[n] ? p_pass[n] : 1'($urandom);
        end else begin
          dn[n] = ($urandom_range(0, 3) == 0);
          ps[n] = 1'($urandom);
        end
      end
    end
    bus.test_done_i = dn;
    bus.test_pass_i = ps;
  end

  // Per-cycle comparison against the timeline.
  always @(negedge clock_i) begin : compare
    logic [NT-1:0] e_ts, e_run, e_fail, e_tmo;
    int e_cur;
    if (chk_en && cyc >= m_s) begin
      e_ts = '0; e_run = '0; e_fail = '0; e_tmo = '0; e_cur = 0;
      for (int n = 0; n < NT; n++) begin
        if (m_launched[n]) begin
          if (m_L[n] == cyc) e_ts[n] = 1'b1;
          if (m_L[n] <= cyc) begin
            e_run[n] = 1'b1;
            e_cur    = n;
          end
          if (m_a[n] + 1 <= cyc) begin
            e_fail[n] = m_failed[n];
            e_tmo[n]  = m_tmo[n];
          end
        end
      end
      check("test_start", bus.test_start_o, e_ts);
      check("busy", bus.busy_o, (cyc <= m_done) ? 1 : 0);
      check("done", bus.done_o, (cyc == m_done) ? 1 : 0);
      check("pass", bus.pass_o, (cyc >= m_done) ? m_verdict : 1'b0);
      check("fail_mask", bus.fail_mask_o, e_fail);
      check("timeout_mask", bus.timeout_mask_o, e_tmo);
      check("run_mask", bus.run_mask_o, e_run);
      check("current", bus.current_o, e_cur);
      if (bus.done_o) n_done++;
    end
  end

  task automatic set_plan(input int d0, input int d1, input int d2, input int d3,
                          input bit [NT-1:0] pass, input bit sof);
    p_d[0] = d0; p_d[1] = d1; p_d[2] = d2; p_d[3] = d3;
    for (int n = 0; n < NT; n++) p_pass[n] = pass[n];
    p_sof = sof;
  endtask

  task automatic begin_run();
    @(negedge clock_i);
    build_model(cyc + 1);
    n_done         = 0;
    stop_drive(p_sof, 1'b1);
    chk_en         = 1'b1;
    resp_en        = 1'b1;
    @(negedge clock_i);
    // The opposite value afterwards must not matter: the mode is latched at start.
    stop_drive(~p_sof, 1'b0);
  endtask

  task automatic stop_drive(input bit sof, input bit st);
    bus.stop_on_fail_i = sof;
    bus.start_i        = st;
  endtask

  task automatic finish_run(input bit extra_start);
    if (extra_start) begin
      int r;
      r = $urandom_range(0, m_done - m_s);
      repeat (r) @(negedge clock_i);
      bus.start_i = 1'b1;
      @(negedge clock_i);
      bus.start_i = 1'b0;
    end
    while (cyc < m_done + 2) @(negedge clock_i);
    chk_en  = 1'b0;
    resp_en = 1'b0;
    check("done_pulses", n_done, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".test_start"}, bus.test_start_o, 0);
    check({tag, ".busy"}, bus.busy_o, 0);
    check({tag, ".done"}, bus.done_o, 0);
    check({tag, ".pass"}, bus.pass_o, 0);
    check({tag, ".fail_mask"}, bus.fail_mask_o, 0);
    check({tag, ".timeout_mask"}, bus.timeout_mask_o, 0);
    check({tag, ".run_mask"}, bus.run_mask_o, 0);
    check({tag, ".current"}, bus.current_o, 0);
  endtask

  task automatic check_final(input string tag, input bit pass, input bit [NT-1:0] fail,
                             input bit [NT-1:0] tmo, input bit [NT-1:0] run);
    check({tag, ".pass_o"}, bus.pass_o, pass);
    check({tag, ".fail_mask_o"}, bus.fail_mask_o, fail);
    check({tag, ".timeout_mask_o"}, bus.timeout_mask_o, tmo);
    check({tag, ".run_mask_o"}, bus.run_mask_o, run);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the end (cycle %0d)", cyc);
    $fatal(1, "bench time limit expired");
  end

  initial begin : main
    int quiet;
    reset_i = 1'b1;
    stop_drive(1'b0, 1'b0);
    set_plan(5, 5, 5, 5, 4'b1111, 1'b0);
    repeat (2) @(negedge clock_i);
    check_zero("in_reset");
    reset_i = 1'b0;
    repeat (2) @(negedge clock_i);
    check_zero("after_reset");

    // All pass, 5-cycle answers: launches at relative cycles 1, 7, 13, 19; done at 25.
    set_plan(5, 5, 5, 5, 4'b1111, 1'b0);
    begin_run();
    check("pin_launch1", m_L[1] - m_s + 1, 7);
    check("pin_launch2", m_L[2] - m_s + 1, 13);
    check("pin_launch3", m_L[3] - m_s + 1, 19);
    check("pin_done", m_done - m_s + 1, 25);
    finish_run(1'b0);
    check_final("all_pass", 1'b1, 4'b0000, 4'b0000, 4'b1111);

    // Test 1 fails, sequence continues.
    set_plan(5, 3, 7, 2, 4'b1101, 1'b0);
    begin_run();
    finish_run(1'b0);
    check_final("t1_fail", 1'b0, 4'b0010, 4'b0000, 4'b1111);

    // Test 2 fails with stop-on-fail; a second start while busy must be ignored.
    set_plan(4, 6, 3, 5, 4'b1011, 1'b1);
    begin_run();
    check("pin_t3_not_run", m_launched[3], 0);
    finish_run(1'b1);
    check_final("t2_stop", 1'b0, 4'b0100, 4'b0000, 4'b0111);

    // Test 0 never answers: timeout edge 16 cycles after launch, next launch right after.
    set_plan(0, 5, 5, 5, 4'b1111, 1'b0);
    begin_run();
    check("pin_timeout_gap", m_L[1] - m_L[0], 17);
    finish_run(1'b0);
    check_final("t0_timeout", 1'b0, 4'b0001, 4'b0001, 4'b1111);

    // Answer exactly 16 cycles after launch is still accepted.
    set_plan(16, 5, 5, 5, 4'b1111, 1'b0);
    begin_run();
    check("pin_late_gap", m_L[1] - m_L[0], 17);
    finish_run(1'b0);
    check_final("t0_last_cycle", 1'b1, 4'b0000, 4'b0000, 4'b1111);

    // Reset while test 2 waits: outputs clear at once and the sequence stays dead.
    set_plan(5, 5, 5, 5, 4'b1111, 1'b0);
    begin_run();
    while (cyc < m_L[2] + 2) @(negedge clock_i);
    chk_en  = 1'b0;
    resp_en = 1'b0;
    #1 reset_i = 1'b1;
    #1 check_zero("async_reset");
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    quiet = 0;
    repeat (40) begin
      @(negedge clock_i);
      if (bus.done_o || bus.busy_o || bus.test_start_o != '0) quiet++;
    end
    check("activity_after_reset", quiet, 0);
    set_plan(5, 4, 6, 3, 4'b1111, 1'b0);
    begin_run();
    finish_run(1'b0);
    check_final("rerun", 1'b1, 4'b0000, 4'b0000, 4'b1111);

    // Randomized plans.
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < NT; n++) begin
        case ($urandom_range(0, 9))
          0:       p_d[n] = 0;
          1:       p_d[n] = T;
          2:       p_d[n] = T + 1;
          3:       p_d[n] = 1;
          default: p_d[n] = $urandom_range(1, T);
        endcase
        p_pass[n] = ($urandom_range(0, 4) != 0);
      end
      p_sof = 1'($urandom);
      begin_run();
      finish_run(1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clock_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
